// File: rtl/pin_ctrl_pkg.sv
// Shared definitions for the pin toggle control path: FSM encoding, default
// widths and elaboration-time helpers.
package pin_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_PIN_W = 64;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past pointer
// and returns the first set bit as a one-hot grant plus its index.
module rr_arbiter
  import pin_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = clog2_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(pointer) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pin_toggle_scheduler.sv
// Round-robin sharing of the pin toggle port: every accepted nonzero request
// becomes one clean enable pulse followed by a guaranteed low gap.
module pin_toggle_scheduler
  import pin_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PIN_W   = DEFAULT_PIN_W,
  parameter int PULSE_W = 1,
  parameter int MIN_GAP = 2,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = clog2_f(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PIN_W-1:0] req_mask,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [PIN_W-1:0]         toggle_mask,
  output logic                     toggle_enable,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         toggle_count
);

  localparam int TMR_W = clog2_f(max_f(PULSE_W, MIN_GAP) + 1);

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [PIN_W-1:0]   sel_mask;
  logic               handshake;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .pointer   (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Grant is one-hot, so OR-ing the gated lanes selects the winner's mask.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_mask = sel_mask | req_mask[i*PIN_W +: PIN_W];
    end
  end

  assign req_ready = (state == IDLE) ? arb_grant : '0;
  assign handshake = (state == IDLE) && (|arb_grant);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tmr           <= '0;
      ptr           <= IDX_W'(NUM_REQ - 1);
      toggle_mask   <= '0;
      toggle_enable <= 1'b0;
      grant_id      <= '0;
      toggle_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            grant_id <= arb_idx;
            ptr      <= arb_idx;
            // A zero mask is consumed without disturbing the pin port.
            if (|sel_mask) begin
              toggle_mask   <= sel_mask;
              toggle_enable <= 1'b1;
              toggle_count  <= toggle_count + CNT_W'(1);
              tmr           <= TMR_W'(PULSE_W - 1);
              state         <= PULSE;
            end
          end
        end
        PULSE: begin
          if (tmr == '0) begin
            toggle_enable <= 1'b0;
            tmr           <= TMR_W'(MIN_GAP - 1);
            state         <= GAP;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        GAP: begin
          if (tmr == '0) state <= IDLE;
          else           tmr   <= tmr - TMR_W'(1);
        end
        default: begin
          toggle_enable <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
